enigma_stream_driver: RTL and testbench

- Host-facing front/back end for the Enigma cipher core: one engine drives the core's input side and collects its output side.
- Takes a message as a ready/valid byte stream, pulses the core's configuration load, and feeds one character per accepted beat into core valid/din.
- Captures core done/dout into a result buffer and returns the transformed stream to the host with back-pressure and an end-of-message marker.
- The core has no stall input, so a credit counter guarantees no result is lost.

---
 rtl/enigma_pkg.sv | 26 ++
 rtl/enigma_result_fifo.sv | 73 +++++++
 rtl/enigma_stream_driver.sv | 213 +++++++++++++++++++++
 tb/tb_enigma_stream_driver.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma stream driver and its result buffer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package enigma_pkg;

   // Default character width of the cipher core's din/dout.
   localparam int DATA_W_DEFAULT = 8;

   // Size of the alphabet the cipher core permutes.
   localparam int ALPHABET_SIZE = 26;

   // Driver control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // One result-buffer entry at the default character width.
   typedef struct packed {
      logic                      last;
      logic [DATA_W_DEFAULT-1:0] data;
   } res_entry_t;

endpackage

// File: rtl/enigma_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding core results for the host.
// Latency: a push is visible at the head on the next cycle; the head is combinational.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               empties the FIFO (wins over push/pop)
//   push, push_data     write one entry
//   pop                 discard the head entry (ignored when empty)
//   head                current head entry (undefined when empty)
//   empty, full, count  fill status
module enigma_result_fifo
   import enigma_pkg::*;
#(
   parameter int WIDTH = DATA_W_DEFAULT + 1,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign empty = (cnt == '0);
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign count = cnt;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; the read side is qualified by empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/enigma_stream_driver.sv
// Host-side driver for the Enigma core: feeds a ready/valid message in, returns results out.
// Latency: host beat -> core_valid one cycle; core_done -> out_valid one cycle (FWFT buffer).
// Backpressure: in_ready drops when in-flight + buffered results reach FIFO_DEPTH, so the
//               stall-less core can never overrun the result buffer.
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   start, cfg_dec                        begin a message (when idle), decrypt select
//   in_valid/in_ready/in_data/in_last     host character stream in
//   out_valid/out_ready/out_data/out_last result stream back to the host
//   busy, msg_done, err                   status: not idle, final result taken, sticky error
//   core_set/core_en/core_valid/core_din/core_dec   drive side of the cipher core
//   core_done/core_dout                   result side of the cipher core
//
// Optional watchdog: define ENIGMA_TIMEOUT_EN to abort a message whose core stops
// answering for TIMEOUT_CYCLES cycles.
module enigma_stream_driver
   import enigma_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEFAULT,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              cfg_dec,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              msg_done,
   output logic              err,
   output logic              core_set,
   output logic              core_en,
   output logic              core_valid,
   output logic [DATA_W-1:0] core_din,
   output logic              core_dec,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_dout
);

   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   state_t          state;
   state_t          state_nxt;
   logic            last_sent;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   credits;
   logic [DATA_W:0] fifo_head;
   logic [DATA_W:0] push_entry;
   logic            fifo_empty;
   logic            fifo_full;
   logic            start_ok;
   logic            issue;
   logic            done_ok;
   logic            push;
   logic            pop;
   logic            head_last;
   logic            err_set;
   logic            timeout;

   // ------------------------------------------------------------------
   // Credit accounting: every accepted character reserves one buffer slot
   // until its result has been handed to the host.
   // ------------------------------------------------------------------
   assign start_ok = (state == IDLE) && start;
   assign credits  = DEPTH_C - outstanding - fifo_count;
   assign in_ready = (state == RUN) && (credits != '0) && !last_sent;
   assign issue    = in_valid && in_ready;

   // A result with nothing in flight cannot belong to this message.
   assign done_ok  = core_done && (outstanding != '0);

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign head_last = fifo_head[DATA_W];
   assign out_data  = out_valid ? fifo_head[DATA_W-1:0] : '0;
   assign out_last  = out_valid && head_last;

   // The core preserves order, so once the final character has been sent the
   // result that empties the in-flight count is the message's last one.
   assign push_entry = {last_sent && (outstanding == CW'(1)), core_dout};
   assign push       = done_ok && (!fifo_full || pop);

   assign err_set = (core_done && (outstanding == '0))
                  || (done_ok && fifo_full && !pop)
                  || timeout;

   enigma_result_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (timeout),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // ------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------
`ifdef ENIGMA_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WDW-1:0] wd_cnt;
   logic           wd_run;

   // Counts consecutive cycles spent waiting on the core with no result.
   assign wd_run  = (outstanding != '0) && !core_done;
   assign timeout = wd_run && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt <= '0;
      end else if (!wd_run || timeout) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout            = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      core_set  = 1'b0;
      core_en   = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = SETUP;
         end
         SETUP: begin
            core_set  = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            core_en = 1'b1;
            if (issue && in_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            core_en = 1'b1;
            if (pop && head_last) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (timeout) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         last_sent   <= 1'b0;
         outstanding <= '0;
         core_valid  <= 1'b0;
         core_din    <= '0;
         core_dec    <= 1'b0;
         err         <= 1'b0;
         msg_done    <= 1'b0;
      end else begin
         state      <= state_nxt;
         core_valid <= issue;
         if (issue)    core_din <= in_data;
         if (start_ok) core_dec <= cfg_dec;

         // A new error in the start cycle survives the clear.
         err <= (err && !start_ok) || err_set;

         msg_done <= (state == DRAIN) && pop && head_last && !timeout;

         if (start_ok || timeout) begin
            last_sent <= 1'b0;
         end else if (issue && in_last) begin
            last_sent <= 1'b1;
         end

         if (timeout) begin
            outstanding <= '0;
         end else begin
            case ({issue, done_ok})
               2'b10:   outstanding <= outstanding + 1'b1;
               2'b01:   outstanding <= outstanding - 1'b1;
               default: outstanding <= outstanding;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_enigma_stream_driver.sv
// Self-checking bench for enigma_stream_driver with a 14-cycle +1 mod 26 core model.
module tb_enigma_stream_driver;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int TO    = 32;
   localparam int LAT   = 14;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          cfg_dec = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          msg_done;
   logic          err;
   logic          core_set;
   logic          core_en;
   logic          core_valid;
   logic [DW-1:0] core_din;
   logic          core_dec;
   logic          core_done;
   logic [DW-1:0] core_dout;

   always #5 clk = ~clk;

   enigma_stream_driver #(
      .DATA_W         (DW),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .cfg_dec    (cfg_dec),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .msg_done   (msg_done),
      .err        (err),
      .core_set   (core_set),
      .core_en    (core_en),
      .core_valid (core_valid),
      .core_din   (core_din),
      .core_dec   (core_dec),
      .core_done  (core_done),
      .core_dout  (core_dout)
   );

   int checks = 0;
   int failures = 0;

   // ---------------- core model: fixed latency, +1 mod 26 on 'A'..'Z' ----------------
   logic [LAT-1:0] pv;
   logic [7:0]     pd [LAT];
   int             valid_seen;
   int             drop_at = -1;
   logic           inj_done = 1'b0;

   function automatic logic [7:0] enc(input logic [7:0] c);
      if (c >= 8'h41 && c <= 8'h5A) return (c == 8'h5A) ? 8'h41 : c + 8'd1;
      return c;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pv         <= '0;
         valid_seen <= 0;
         for (int i = 0; i < LAT; i++) pd[i] <= '0;
      end else begin
         pv    <= {pv[LAT-2:0], core_valid && (valid_seen != drop_at)};
         pd[0] <= enc(core_din);
         for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
         if (core_valid) valid_seen <= valid_seen + 1;
      end
   end

   assign core_done = pv[LAT-1] | inj_done;
   assign core_dout = pd[LAT-1];

   // ---------------- monitor (samples on the falling edge) ----------------
   int         cyc = 0;
   int         set_cnt = 0;
   int         valid_cnt = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         last_pop_cyc = 0;
   logic       busy_at_done = 1'b1;
   logic [7:0] rx_q [$];
   logic       rl_q [$];

   always @(negedge clk) begin
      cyc++;
      if (core_set)   set_cnt++;
      if (core_valid) valid_cnt++;
      if (msg_done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
      if (out_valid && out_ready) begin
         rx_q.push_back(out_data);
         rl_q.push_back(out_last);
         if (out_last) last_pop_cyc = cyc;
      end
   end

   function automatic string rx_str(input int from);
      string s = "";
      for (int i = from; i < rx_q.size(); i++) s = {s, $sformatf("%c", rx_q[i])};
      return s;
   endfunction

   function automatic int rx_lasts(input int from);
      int n = 0;
      for (int i = from; i < rl_q.size(); i++) if (rl_q[i]) n++;
      return n;
   endfunction

   function automatic int rx_lastpos(input int from);
      for (int i = from; i < rl_q.size(); i++) if (rl_q[i]) return i - from;
      return -1;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic dec);
      cfg_dec = dec;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic send_msg(input string s, input bit with_last);
      for (int i = 0; i < s.len(); i++) begin
         int budget;
         bit acc;
         budget   = 500;
         in_valid = 1'b1;
         in_data  = s[i];
         in_last  = with_last && (i == s.len() - 1);
         do begin
            acc = in_ready;
            tick();
            budget--;
         end while (!acc && budget > 0);
         checks++;
         if (!acc) begin
            failures++;
            $display("FAIL send_accept char=%0d in_ready=%b required=1", i, in_ready);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_msg_done(input int base);
      int budget;
      budget = 1000;
      while (done_cnt == base && budget > 0) begin
         tick();
         budget--;
      end
      checks++;
      if (done_cnt == base) begin
         failures++;
         $display("FAIL msg_done_wait seen=%0d required=%0d", done_cnt - base, 1);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({in_ready, out_valid, out_last, busy, msg_done, err, core_set, core_en, core_valid, core_dec} !== 10'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b required=%b",
                  {in_ready, out_valid, out_last, busy, msg_done, err, core_set, core_en, core_valid, core_dec}, 10'b0);
      end
      checks++;
      if (core_din !== 8'h00 || out_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_data core_din=%h out_data=%h required=00", core_din, out_data);
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset busy=%b in_ready=%b required=0", busy, in_ready);
      end
   endtask

   task automatic test_basic();
      int bs, bv, bd, rb;
      string got;
      bs = set_cnt; bv = valid_cnt; bd = done_cnt; rb = rx_q.size();
      out_ready = 1'b1;
      pulse_start(1'b0);
      checks++;
      if (core_set !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_setup core_set=%b busy=%b required=1", core_set, busy);
      end
      send_msg("HELLO", 1'b1);
      wait_msg_done(bd);
      got = rx_str(rb);
      checks++;
      if (set_cnt - bs !== 1) begin
         failures++;
         $display("FAIL basic_core_set_pulses got=%0d required=1", set_cnt - bs);
      end
      checks++;
      if (valid_cnt - bv !== 5) begin
         failures++;
         $display("FAIL basic_core_valid_pulses got=%0d required=5", valid_cnt - bv);
      end
      checks++;
      if (got != "IFMMP") begin
         failures++;
         $display("FAIL basic_data got=%s required=IFMMP", got);
      end
      checks++;
      if (rx_lasts(rb) !== 1 || rx_lastpos(rb) !== 4) begin
         failures++;
         $display("FAIL basic_out_last count=%0d pos=%0d required=1,4", rx_lasts(rb), rx_lastpos(rb));
      end
      checks++;
      if (done_cyc - last_pop_cyc !== 1) begin
         failures++;
         $display("FAIL basic_msg_done_delay got=%0d required=1", done_cyc - last_pop_cyc);
      end
      checks++;
      if (busy_at_done !== 1'b0) begin
         failures++;
         $display("FAIL basic_busy_fall got=%b required=0", busy_at_done);
      end
      tick();
      checks++;
      if (msg_done !== 1'b0 || done_cnt - bd !== 1) begin
         failures++;
         $display("FAIL basic_msg_done_pulse level=%b count=%0d required=0,1", msg_done, done_cnt - bd);
      end
   endtask

   task automatic test_back_to_back();
      int bv, bd, rb;
      string got;
      bv = valid_cnt; bd = done_cnt; rb = rx_q.size();
      out_ready = 1'b0;
      pulse_start(1'b0);
      fork
         send_msg("ABCDEFGHIJ", 1'b1);
         begin
            repeat (60) tick();
            checks++;
            if (valid_cnt - bv !== DEPTH) begin
               failures++;
               $display("FAIL bp_issue_count got=%0d required=%0d", valid_cnt - bv, DEPTH);
            end
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               failures++;
               $display("FAIL bp_stall in_ready=%b out_valid=%b required=0,1", in_ready, out_valid);
            end
            checks++;
            if (rx_q.size() !== rb) begin
               failures++;
               $display("FAIL bp_no_pop got=%0d required=0", rx_q.size() - rb);
            end
            out_ready = 1'b1;
         end
      join
      wait_msg_done(bd);
      got = rx_str(rb);
      checks++;
      if (got != "BCDEFGHIJK") begin
         failures++;
         $display("FAIL bp_data got=%s required=BCDEFGHIJK", got);
      end
      checks++;
      if (rx_lasts(rb) !== 1 || rx_lastpos(rb) !== 9) begin
         failures++;
         $display("FAIL bp_out_last count=%0d pos=%0d required=1,9", rx_lasts(rb), rx_lastpos(rb));
      end
      checks++;
      if (valid_cnt - bv !== 10) begin
         failures++;
         $display("FAIL bp_total_issue got=%0d required=10", valid_cnt - bv);
      end
   endtask

   task automatic test_single();
      int bd, rb;
      string got;
      bd = done_cnt; rb = rx_q.size();
      out_ready = 1'b1;
      pulse_start(1'b1);
      checks++;
      if (core_dec !== 1'b1) begin
         failures++;
         $display("FAIL single_core_dec got=%b required=1", core_dec);
      end
      send_msg("A", 1'b1);
      wait_msg_done(bd);
      got = rx_str(rb);
      checks++;
      if (got != "B" || rx_lastpos(rb) !== 0) begin
         failures++;
         $display("FAIL single_data got=%s lastpos=%0d required=B,0", got, rx_lastpos(rb));
      end
      tick();
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_idle busy=%b in_ready=%b required=0", busy, in_ready);
      end
   endtask

   task automatic test_error();
      int bd, rb;
      string got;
      bd = done_cnt; rb = rx_q.size();
      out_ready = 1'b1;
      inj_done  = 1'b1;
      tick();
      inj_done  = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_stray_done got=%b required=1", err);
      end
      repeat (4) tick();
      checks++;
      if (out_valid !== 1'b0 || rx_q.size() !== rb || err !== 1'b1) begin
         failures++;
         $display("FAIL err_discard out_valid=%b pops=%0d err=%b required=0,0,1", out_valid, rx_q.size() - rb, err);
      end
      pulse_start(1'b0);
      checks++;
      if (err !== 1'b0 || core_dec !== 1'b0) begin
         failures++;
         $display("FAIL err_clear_on_start err=%b core_dec=%b required=0,0", err, core_dec);
      end
      send_msg("Z", 1'b1);
      wait_msg_done(bd);
      got = rx_str(rb);
      checks++;
      if (got != "A") begin
         failures++;
         $display("FAIL err_wrap_data got=%s required=A", got);
      end
   endtask

   task automatic test_reset_mid();
      int bd, rb;
      string got;
      rb = rx_q.size();
      out_ready = 1'b1;
      pulse_start(1'b1);
      send_msg("ABC", 1'b0);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_last, busy, msg_done, err, core_set, core_en, core_valid, core_dec} !== 10'b0
          || core_din !== 8'h00 || out_data !== 8'h00) begin
         failures++;
         $display("FAIL midreset_outputs ctrl=%b core_din=%h out_data=%h required=0",
                  {in_ready, out_valid, out_last, busy, msg_done, err, core_set, core_en, core_valid, core_dec},
                  core_din, out_data);
      end
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (20) tick();
      checks++;
      if (rx_q.size() !== rb || err !== 1'b0) begin
         failures++;
         $display("FAIL midreset_discard pops=%0d err=%b required=0,0", rx_q.size() - rb, err);
      end
      bd = done_cnt; rb = rx_q.size();
      pulse_start(1'b0);
      send_msg("OK", 1'b1);
      wait_msg_done(bd);
      got = rx_str(rb);
      checks++;
      if (got != "PL" || rx_lastpos(rb) !== 1) begin
         failures++;
         $display("FAIL midreset_recover got=%s lastpos=%0d required=PL,1", got, rx_lastpos(rb));
      end
   endtask

`ifdef ENIGMA_TIMEOUT_EN
   task automatic test_timeout();
      int bd, rb, budget;
      string got;
      bd = done_cnt; rb = rx_q.size();
      out_ready = 1'b1;
      drop_at   = valid_seen + 1;
      pulse_start(1'b0);
      send_msg("ABC", 1'b1);
      budget = 300;
      while (busy && budget > 0) begin
         tick();
         budget--;
      end
      got = rx_str(rb);
      checks++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_abort busy=%b err=%b required=0,1", busy, err);
      end
      checks++;
      if (done_cnt - bd !== 0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL timeout_no_done msg_done=%0d out_valid=%b required=0,0", done_cnt - bd, out_valid);
      end
      checks++;
      if (got != "BD" || rx_lasts(rb) !== 0) begin
         failures++;
         $display("FAIL timeout_data got=%s lasts=%0d required=BD,0", got, rx_lasts(rb));
      end
      drop_at = -1;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_single();
      test_error();
      test_reset_mid();
`ifdef ENIGMA_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit cycles=%0d required=finish", cyc);
      $fatal(1, "time limit");
   end

endmodule
